// File: rtl/controle_busca_binaria.sv
// controle_busca_binaria: binary-search controller driving comparator operand A until A equals the hidden B.
// Define BUSCA_VERIFICA_ONEHOT_EN to flag non-one-hot comparator feedback as an error.
module controle_busca_binaria #(
  parameter int N      = 4,
  parameter int ESPERA = 1
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      INICIAR,
  input  logic                      A_maior_que_B,
  input  logic                      A_menor_que_B,
  input  logic                      A_igual_a_B,
  output logic [N-1:0]              GUESS,
  output logic                      OCUPADO,
  output logic                      PRONTO,
  output logic                      ACHOU,
  output logic                      ERRO,
  output logic [$clog2(N+2)-1:0]    TENTATIVAS
);
  typedef enum logic [2:0] {S_OCIOSO, S_PROPOE, S_ESPERA, S_AVALIA, S_FIM} estado_t;
  localparam logic [3:0] ESP = 4'(ESPERA);
  estado_t      estado_q;
  logic [N:0]   lo_q, hi_q;
  logic [3:0]   espera_q;
  logic [N-1:0] meio;
  logic [N:0]   g_ext;
  logic         igual, maior, invalido;
  // the sum keeps its carry bit so the midpoint of the top interval stays correct
  assign meio  = N'((lo_q + hi_q) >> 1);
  assign g_ext = {1'b0, GUESS};
`ifdef BUSCA_VERIFICA_ONEHOT_EN
  assign invalido = !({A_maior_que_B, A_menor_que_B, A_igual_a_B} inside {3'b100, 3'b010, 3'b001});
  assign igual    = A_igual_a_B;
  assign maior    = A_maior_que_B;
`else
  assign invalido = 1'b0;
  assign igual    = A_igual_a_B;
  assign maior    = !A_igual_a_B && A_maior_que_B;
`endif
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      estado_q   <= S_OCIOSO;
      lo_q       <= '0;
      hi_q       <= '0;
      espera_q   <= '0;
      GUESS      <= '0;
      OCUPADO    <= 1'b0;
      PRONTO     <= 1'b0;
      ACHOU      <= 1'b0;
      ERRO       <= 1'b0;
      TENTATIVAS <= '0;
    end else begin
      case (estado_q)
        S_OCIOSO, S_FIM: if (INICIAR) begin
          lo_q       <= '0;
          hi_q       <= {1'b0, {N{1'b1}}};
          TENTATIVAS <= '0;
          PRONTO     <= 1'b0;
          ACHOU      <= 1'b0;
          ERRO       <= 1'b0;
          OCUPADO    <= 1'b1;
          estado_q   <= S_PROPOE;
        end
        S_PROPOE: begin
          GUESS      <= meio;
          TENTATIVAS <= TENTATIVAS + 1'b1;
          espera_q   <= ESP;
          estado_q   <= (ESP == 4'd0) ? S_AVALIA : S_ESPERA;
        end
        S_ESPERA: begin
          espera_q <= espera_q - 4'd1;
          if (espera_q <= 4'd1) estado_q <= S_AVALIA;
        end
        S_AVALIA: begin
          // empty-interval checks fire before any bound could wrap
          if (invalido || igual || (maior && g_ext == lo_q) || (!maior && g_ext == hi_q)) begin
            ACHOU    <= !invalido && igual;
            ERRO     <= invalido || !igual;
            PRONTO   <= 1'b1;
            OCUPADO  <= 1'b0;
            estado_q <= S_FIM;
          end else begin
            if (maior) hi_q <= g_ext - 1'b1;
            else lo_q <= g_ext + 1'b1;
            estado_q <= S_PROPOE;
          end
        end
        default: estado_q <= S_OCIOSO;
      endcase
    end
  end
endmodule

// File: tb/tb_controle_busca_binaria.sv
// tb_controle_busca_binaria: directed checks of the binary-search controller against hand-computed searches.
module tb_controle_busca_binaria;
  logic       CLK = 0, CLR = 1, INICIAR = 0;
  logic       maior, menor, igual;
  logic [3:0] GUESS;
  logic       OCUPADO, PRONTO, ACHOU, ERRO;
  logic [2:0] TENTATIVAS;
  logic [3:0] hid = 0;
  int         mode = 0;
  logic [31:0] gs;
  int         lat, ntests = 0, nfail = 0;

  controle_busca_binaria #(.N(4), .ESPERA(1)) dut (
    .CLK(CLK), .CLR(CLR), .INICIAR(INICIAR),
    .A_maior_que_B(maior), .A_menor_que_B(menor), .A_igual_a_B(igual),
    .GUESS(GUESS), .OCUPADO(OCUPADO), .PRONTO(PRONTO), .ACHOU(ACHOU),
    .ERRO(ERRO), .TENTATIVAS(TENTATIVAS)
  );

  always #5 CLK = ~CLK;

  // mode 0: honest comparator, 1: stuck at maior, 2: maior and igual together
  always_comb begin
    maior = (mode == 0) ? (GUESS > hid) : 1'b1;
    menor = (mode == 0) ? (GUESS < hid) : 1'b0;
    igual = (mode == 0) ? (GUESS == hid) : (mode == 2);
  end

  // Starts a search from a post-edge point and records GUESS once per try (ESPERA=1 -> 3 cycles/try).
  task automatic run(input logic [3:0] h, input int md);
    hid = h; mode = md; gs = 0;
    INICIAR = 1;
    @(posedge CLK); #1 INICIAR = 0;
    lat = 1;
    while (!PRONTO && lat < 60) begin
      @(posedge CLK); #1;
      if (lat % 3 == 1) gs = {gs[27:0], GUESS};
      lat++;
    end
  endtask

  task automatic test_reset;
    CLR = 1;
    repeat (2) @(posedge CLK);
    #1;
    ntests++; if ({GUESS, OCUPADO, PRONTO, ACHOU, ERRO, TENTATIVAS} !== 11'd0) begin nfail++; $display("FAIL reset_outputs got %h want 0", {GUESS, OCUPADO, PRONTO, ACHOU, ERRO, TENTATIVAS}); end
    CLR = 0;
    repeat (3) @(posedge CLK);
    #1;
    ntests++; if ({OCUPADO, PRONTO} !== 2'b00) begin nfail++; $display("FAIL idle_hold got %b want 00", {OCUPADO, PRONTO}); end
  endtask

  task automatic test_find_9;
    run(4'd9, 0);
    ntests++; if (gs !== 32'h0000_07B9) begin nfail++; $display("FAIL find9_seq got %h want 000007b9", gs); end
    ntests++; if ({PRONTO, ACHOU, ERRO, OCUPADO} !== 4'b1100) begin nfail++; $display("FAIL find9_flags got %b want 1100", {PRONTO, ACHOU, ERRO, OCUPADO}); end
    ntests++; if (TENTATIVAS !== 3'd3) begin nfail++; $display("FAIL find9_tries got %0d want 3", TENTATIVAS); end
    ntests++; if (lat !== 10) begin nfail++; $display("FAIL find9_latency got %0d want 10", lat); end
    hid = 4'd2;
    repeat (4) @(posedge CLK);
    #1;
    ntests++; if ({PRONTO, ACHOU, GUESS, TENTATIVAS} !== {2'b11, 4'd9, 3'd3}) begin nfail++; $display("FAIL fim_hold got %h want %h", {PRONTO, ACHOU, GUESS, TENTATIVAS}, {2'b11, 4'd9, 3'd3}); end
  endtask

  task automatic test_find_15;
    run(4'd15, 0);
    ntests++; if (gs !== 32'h0007_BDEF) begin nfail++; $display("FAIL find15_seq got %h want 0007bdef", gs); end
    ntests++; if ({ACHOU, ERRO, TENTATIVAS} !== {2'b10, 3'd5}) begin nfail++; $display("FAIL find15_result got %b want 10101", {ACHOU, ERRO, TENTATIVAS}); end
    ntests++; if (lat !== 16) begin nfail++; $display("FAIL find15_latency got %0d want 16", lat); end
  endtask

  task automatic test_find_0;
    run(4'd0, 0);
    ntests++; if (gs !== 32'h0000_7310) begin nfail++; $display("FAIL find0_seq got %h want 00007310", gs); end
    ntests++; if ({ACHOU, ERRO, TENTATIVAS} !== {2'b10, 3'd4}) begin nfail++; $display("FAIL find0_result got %b want 10100", {ACHOU, ERRO, TENTATIVAS}); end
  endtask

  task automatic test_stuck_maior;
    run(4'd5, 1);
    ntests++; if (gs !== 32'h0000_7310) begin nfail++; $display("FAIL stuck_seq got %h want 00007310", gs); end
    ntests++; if ({PRONTO, ACHOU, ERRO, TENTATIVAS} !== {3'b101, 3'd4}) begin nfail++; $display("FAIL stuck_result got %b want 101100", {PRONTO, ACHOU, ERRO, TENTATIVAS}); end
  endtask

  task automatic test_clr_mid;
    hid = 4'd9; mode = 0;
    INICIAR = 1;
    @(posedge CLK); #1 INICIAR = 0;
    repeat (4) @(posedge CLK);
    #1;
    ntests++; if ({OCUPADO, TENTATIVAS, GUESS} !== {1'b1, 3'd2, 4'd11}) begin nfail++; $display("FAIL clr_pre got %h want %h", {OCUPADO, TENTATIVAS, GUESS}, {1'b1, 3'd2, 4'd11}); end
    CLR = 1;
    #1;
    ntests++; if ({GUESS, OCUPADO, PRONTO, ACHOU, ERRO, TENTATIVAS} !== 11'd0) begin nfail++; $display("FAIL clr_async got %h want 0", {GUESS, OCUPADO, PRONTO, ACHOU, ERRO, TENTATIVAS}); end
    #1 CLR = 0;
    @(posedge CLK); #1;
    run(4'd9, 0);
    ntests++; if ({gs, ACHOU, TENTATIVAS} !== {32'h0000_07B9, 1'b1, 3'd3}) begin nfail++; $display("FAIL clr_rerun got %h want %h", {gs, ACHOU, TENTATIVAS}, {32'h0000_07B9, 1'b1, 3'd3}); end
  endtask

  task automatic test_back_to_back;
    run(4'd6, 0);
    ntests++; if ({PRONTO, ACHOU, GUESS} !== {2'b11, 4'd6}) begin nfail++; $display("FAIL b2b_first got %h want %h", {PRONTO, ACHOU, GUESS}, {2'b11, 4'd6}); end
    INICIAR = 1;
    @(posedge CLK); #1;
    ntests++; if ({PRONTO, ACHOU, OCUPADO, TENTATIVAS} !== {3'b001, 3'd0}) begin nfail++; $display("FAIL b2b_restart got %b want 001000", {PRONTO, ACHOU, OCUPADO, TENTATIVAS}); end
    INICIAR = 0;
    hid = 4'd12;
    lat = 1;
    while (!PRONTO && lat < 60) begin @(posedge CLK); #1; lat++; end
    ntests++; if ({ACHOU, GUESS, TENTATIVAS} !== {1'b1, 4'd12, 3'd4}) begin nfail++; $display("FAIL b2b_second got %h want %h", {ACHOU, GUESS, TENTATIVAS}, {1'b1, 4'd12, 3'd4}); end
    ntests++; if (lat !== 13) begin nfail++; $display("FAIL b2b_latency got %0d want 13", lat); end
  endtask

  task automatic test_multi_feedback;
    run(4'd3, 2);
`ifdef BUSCA_VERIFICA_ONEHOT_EN
    ntests++; if ({PRONTO, ACHOU, ERRO, TENTATIVAS} !== {3'b101, 3'd1}) begin nfail++; $display("FAIL multi_fb got %b want 101001", {PRONTO, ACHOU, ERRO, TENTATIVAS}); end
`else
    ntests++; if ({PRONTO, ACHOU, ERRO, TENTATIVAS, GUESS} !== {3'b110, 3'd1, 4'd7}) begin nfail++; $display("FAIL multi_fb got %b want 1100010111", {PRONTO, ACHOU, ERRO, TENTATIVAS, GUESS}); end
`endif
    ntests++; if (lat !== 4) begin nfail++; $display("FAIL multi_fb_latency got %0d want 4", lat); end
  endtask

  initial begin
    test_reset;
    test_find_9;
    test_find_15;
    test_find_0;
    test_stuck_maior;
    test_clr_mid;
    test_back_to_back;
    test_multi_feedback;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
